rx_prbs_checker: RTL and testbench
==================================

RX_PRBS_CHECKER -- requirements
Module: rx_prbs_checker

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH SHALL default to 32; it is the AXI-Lite data width.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH SHALL default to 32; it is the AXI-Lite address width.
REQ-003 Parameter C_LOCK_CNT SHALL default to 4; it is the number of consecutive matches needed to lock.
REQ-004 Parameter C_LOSS_CNT SHALL default to 4; it is the number of consecutive locked errors that drop lock.
REQ-005 Port s_axi_aclk SHALL be input, 1 bit: clock.
REQ-006 Port s_axi_aresetn SHALL be input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port s_axi_awaddr SHALL be input, C_S_AXI_ADDR_WIDTH bits: write address.
REQ-008 Port s_axi_awvalid SHALL be input, 1 bit; s_axi_awready SHALL be output, 1 bit.
REQ-009 Port s_axi_wdata SHALL be input, C_S_AXI_DATA_WIDTH bits; s_axi_wstrb SHALL be input, C_S_AXI_DATA_WIDTH/8 bits.
REQ-010 Port s_axi_wvalid SHALL be input, 1 bit; s_axi_wready SHALL be output, 1 bit.
REQ-011 Port s_axi_bresp SHALL be output, 2 bits; s_axi_bvalid SHALL be output, 1 bit; s_axi_bready SHALL be input, 1 bit.
REQ-012 Port s_axi_araddr SHALL be input, C_S_AXI_ADDR_WIDTH bits; s_axi_arvalid SHALL be input, 1 bit; s_axi_arready SHALL be output, 1 bit.
REQ-013 Port s_axi_rdata SHALL be output, C_S_AXI_DATA_WIDTH bits; s_axi_rresp SHALL be output, 2 bits.
REQ-014 Port s_axi_rvalid SHALL be output, 1 bit; s_axi_rready SHALL be input, 1 bit.
REQ-015 Port s_axis_tvalid SHALL be input, 1 bit; s_axis_tready SHALL be output, 1 bit.
REQ-016 Port s_axis_sof SHALL be input, 1 bit: start of frame; s_axis_tdata SHALL be input, 32 bits: stream data.
REQ-017 Port o_locked SHALL be output, 1 bit: the checker is in LOCKED.

Function
REQ-018 Register map SHALL be (byte address, bits [4:2] decoded):
- 0x00 CTRL: bit0 enable (RW); bit1 clear (write-1 pulse, reads 0).
- 0x04 STATUS (RO): [1:0] state, IDLE=0, SEARCH=1, LOCKED=2.
- 0x08 WORD_CNT, 0x0C ERR_WORD_CNT, 0x10 BIT_ERR_CNT, 0x14 SOF_CNT (all RO).
- Unmapped reads SHALL return 0; unmapped writes SHALL be ignored.
REQ-019 AXI-Lite writes SHALL behave as follows:
- awready and wready assert together for one cycle when awvalid and wvalid are both high and bvalid is low.
- bvalid asserts the next cycle with bresp=00 and holds until bready.
- wstrb is ignored; full-word writes are assumed.
REQ-020 AXI-Lite reads SHALL behave as follows:
- arready pulses for one cycle when arvalid is high and rvalid is low.
- rdata and rvalid are registered the next cycle with rresp=00, held until rready.
REQ-021 Stream handshake SHALL follow these rules:
- s_axis_tready equals CTRL.enable.
- A beat is accepted only when tvalid and tready are both high.
- No backpressure exists beyond tready.
REQ-022 NEXT(w) SHALL be {w[30:0], w[31]^w[21]^w[1]^w[0]}.
REQ-023 FSM transitions SHALL be:
- IDLE to SEARCH when enable rises.
- Any state to IDLE within one cycle when enable falls; match/loss counters are zeroed.
REQ-024 In SEARCH, the first accepted beat SHALL only load the expected register with NEXT(beat).
- Each later beat equal to the expected value increments match_cnt; a mismatch zeroes it.
- Expected always reloads with NEXT(received).
- When match_cnt reaches C_LOCK_CNT, the state moves to LOCKED on the next cycle.
REQ-025 In LOCKED, expected SHALL advance as NEXT(expected), independent of received data.
- A mismatch increments loss_cnt; a match zeroes it.
- When loss_cnt reaches C_LOSS_CNT, the state moves to SEARCH with match_cnt=0, and expected reloads with NEXT(received).
REQ-026 Counters SHALL be 32 bits wide and saturate at 0xFFFFFFFF.
- WORD_CNT increments on each accepted beat in LOCKED.
- ERR_WORD_CNT increments on each LOCKED mismatch.
- BIT_ERR_CNT adds popcount(received XOR expected) in LOCKED; the add saturates.
- SOF_CNT increments on each accepted beat with sof=1, in any non-IDLE state.
REQ-027 A clear pulse SHALL zero all four counters.
- If clear coincides with a beat in the same cycle, clear wins and that beat is not counted.
- Lock state is unaffected by clear.
REQ-028 o_locked SHALL be registered and equal to (state==LOCKED).

Reset
REQ-029 On reset, the block SHALL drive:
- state IDLE, CTRL=0, and all counters, match_cnt, loss_cnt and expected at 0.
- awready, wready, arready, bvalid, rvalid, s_axis_tready and o_locked all 0.
- bresp=00, rresp=00, rdata=0.
REQ-030 Reset asserted mid-frame SHALL abort immediately, and the block SHALL require enable to be rewritten after release.

Verification
REQ-031 Write CTRL=1, then stream 0x00000001, 0x00000003, 0x00000006, and continue with NEXT for 10 beats in total. Required: o_locked=1 after the 5th beat; WORD_CNT=5; both error counters=0.
REQ-032 While locked, corrupt one beat by XOR 0x0000000F, then resume the correct sequence. Required: ERR_WORD_CNT=1, BIT_ERR_CNT=4, lock retained.
REQ-033 While locked, send 4 consecutive corrupted beats. Required: STATUS=1 (SEARCH), o_locked=0, ERR_WORD_CNT=4.
REQ-034 Write clear in the same cycle as an accepted beat. Required: all counters read 0 afterwards.
REQ-035 Send 3 beats with sof=1. Required: SOF_CNT=3. Then write CTRL=0. Required: STATUS=0 and s_axis_tready=0 on the next cycle.
REQ-036 Read from 0x1C. Required: rdata=0 and rresp=00.

Source files
------------

// File: rtl/rx_prbs_checker.sv
// rx_prbs_checker
//   Checks an incoming 32-bit PRBS stream (NEXT(w) = {w[30:0], w[31]^w[21]^w[1]^w[0]}).
//   The checker syncs to the stream in SEARCH, tracks it in LOCKED and counts
//   words, errored words, bit errors and start-of-frame beats. It is controlled
//   and observed through an AXI4-Lite slave.
//
// Ports
//   s_axi_aclk / s_axi_aresetn : clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b* : AXI-Lite write channels (wstrb ignored)
//   s_axi_ar* / s_axi_r*            : AXI-Lite read channels
//   s_axis_tvalid / s_axis_tready / s_axis_sof / s_axis_tdata : input stream
//   o_locked : registered, high while the checker is in LOCKED
//
// Register map (byte address, bits [4:2] decoded)
//   0x00 CTRL  bit0 enable (RW), bit1 clear (write-1 pulse, reads 0)
//   0x04 STATUS [1:0] state: IDLE=0 SEARCH=1 LOCKED=2
//   0x08 WORD_CNT  0x0C ERR_WORD_CNT  0x10 BIT_ERR_CNT  0x14 SOF_CNT
//
// Handshakes: a transfer on any channel happens on the clock edge where its
// valid and ready are both high. The slave raises awready/wready (arready) for
// exactly one cycle and holds bvalid (rvalid) until the master's bready (rready).
module rx_prbs_checker #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_LOCK_CNT         = 4,
    parameter int C_LOSS_CNT         = 4
) (
    input  logic                              s_axi_aclk,
    input  logic                              s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_sof,
    input  logic [31:0]                       s_axis_tdata,
    output logic                              o_locked
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [31:0] prbs_next(input logic [31:0] w);
        return {w[30:0], w[31] ^ w[21] ^ w[1] ^ w[0]};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t      r_state;
    logic        r_locked;
    logic        r_primed;      // SEARCH has seen its first beat
    logic [31:0] r_match_cnt;
    logic [31:0] r_loss_cnt;
    logic [31:0] r_expected;
    logic        r_enable;
    logic        r_awready;
    logic        r_bvalid;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [31:0] r_word_cnt;
    logic [31:0] r_err_word_cnt;
    logic [31:0] r_bit_err_cnt;
    logic [31:0] r_sof_cnt;

    logic        w_wr_en;
    logic        w_wr_ctrl;
    logic        w_clear;
    logic        w_enable_next;
    logic        w_beat;
    logic        w_match;
    logic        w_rd_en;
    logic [31:0] w_diff;
    logic [5:0]  w_popcnt;
    logic [32:0] w_bit_sum;
    logic [31:0] w_rd_word;
    logic        w_unused;

    assign w_wr_en   = r_awready && s_axi_awvalid && s_axi_wvalid;
    assign w_wr_ctrl = w_wr_en && (s_axi_awaddr[4:2] == 3'd0);
    assign w_clear   = w_wr_ctrl && s_axi_wdata[1];
    // The FSM follows the enable value being written this cycle, so a
    // disable reaches IDLE on the same edge that clears tready.
    assign w_enable_next = w_wr_ctrl ? s_axi_wdata[0] : r_enable;
    assign w_beat    = s_axis_tvalid && r_enable;
    assign w_diff    = s_axis_tdata ^ r_expected;
    assign w_match   = (w_diff == 32'd0);
    assign w_rd_en   = r_arready && s_axi_arvalid;
    assign w_bit_sum = {1'b0, r_bit_err_cnt} + {27'd0, w_popcnt};

    always_comb begin
        w_popcnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            w_popcnt = w_popcnt + {5'd0, w_diff[i]};
        end
    end

    always_comb begin
        w_rd_word = 32'd0;
        case (s_axi_araddr[4:2])
            3'd0:    w_rd_word = {31'd0, r_enable};
            3'd1:    w_rd_word = {30'd0, r_state};
            3'd2:    w_rd_word = r_word_cnt;
            3'd3:    w_rd_word = r_err_word_cnt;
            3'd4:    w_rd_word = r_bit_err_cnt;
            3'd5:    w_rd_word = r_sof_cnt;
            default: w_rd_word = 32'd0;
        endcase
    end

    // AXI-Lite write channel and CTRL.enable
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_enable  <= 1'b0;
        end else begin
            r_awready <= !r_awready && s_axi_awvalid && s_axi_wvalid && !r_bvalid;
            if (w_wr_en) begin
                r_bvalid <= 1'b1;
            end else if (s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
            r_enable <= w_enable_next;
        end
    end

    // AXI-Lite read channel
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_arready <= !r_arready && s_axi_arvalid && !r_rvalid;
            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_word;
            end else if (s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Lock FSM. Lock and loss take effect on the edge of the beat that
    // completes the run, so the very next beat is already judged in the
    // new state.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state     <= ST_IDLE;
            r_locked    <= 1'b0;
            r_primed    <= 1'b0;
            r_match_cnt <= 32'd0;
            r_loss_cnt  <= 32'd0;
            r_expected  <= 32'd0;
        end else if (!w_enable_next) begin
            r_state     <= ST_IDLE;
            r_locked    <= 1'b0;
            r_primed    <= 1'b0;
            r_match_cnt <= 32'd0;
            r_loss_cnt  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_SEARCH;
                    r_primed    <= 1'b0;
                    r_match_cnt <= 32'd0;
                end
                ST_SEARCH: begin
                    if (w_beat) begin
                        r_expected <= prbs_next(s_axis_tdata);
                        if (!r_primed) begin
                            r_primed <= 1'b1;
                        end else if (w_match) begin
                            r_match_cnt <= r_match_cnt + 32'd1;
                            if (r_match_cnt + 32'd1 >= 32'(C_LOCK_CNT)) begin
                                r_state    <= ST_LOCKED;
                                r_locked   <= 1'b1;
                                r_loss_cnt <= 32'd0;
                            end
                        end else begin
                            r_match_cnt <= 32'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_beat) begin
                        if (w_match) begin
                            r_loss_cnt <= 32'd0;
                            r_expected <= prbs_next(r_expected);
                        end else if (r_loss_cnt + 32'd1 >= 32'(C_LOSS_CNT)) begin
                            r_state     <= ST_SEARCH;
                            r_locked    <= 1'b0;
                            r_match_cnt <= 32'd0;
                            r_loss_cnt  <= 32'd0;
                            r_expected  <= prbs_next(s_axis_tdata);
                        end else begin
                            r_loss_cnt <= r_loss_cnt + 32'd1;
                            r_expected <= prbs_next(r_expected);
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Statistics counters; a clear on the same edge as a beat wins.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_word_cnt     <= 32'd0;
            r_err_word_cnt <= 32'd0;
            r_bit_err_cnt  <= 32'd0;
            r_sof_cnt      <= 32'd0;
        end else if (w_clear) begin
            r_word_cnt     <= 32'd0;
            r_err_word_cnt <= 32'd0;
            r_bit_err_cnt  <= 32'd0;
            r_sof_cnt      <= 32'd0;
        end else if (w_beat) begin
            if (s_axis_sof && (r_state != ST_IDLE)) begin
                r_sof_cnt <= sat_inc(r_sof_cnt);
            end
            if (r_state == ST_LOCKED) begin
                r_word_cnt    <= sat_inc(r_word_cnt);
                r_bit_err_cnt <= w_bit_sum[32] ? 32'hFFFF_FFFF : w_bit_sum[31:0];
                if (!w_match) begin
                    r_err_word_cnt <= sat_inc(r_err_word_cnt);
                end
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_awready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rdata   = C_S_AXI_DATA_WIDTH'(r_rdata);
    assign s_axis_tready = r_enable;
    assign o_locked      = r_locked;

    assign w_unused = ^{s_axi_wstrb, s_axi_wdata[C_S_AXI_DATA_WIDTH-1:2],
                        s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:5], s_axi_awaddr[1:0],
                        s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:5], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_rx_prbs_checker.sv
// Testbench for rx_prbs_checker: directed steps plus randomized PRBS streams
// compared against a behavioural model of the lock rules and counters.
module tb_rx_prbs_checker;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 4;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_WORD   = 32'h08;
    localparam logic [31:0] A_ERR    = 32'h0C;
    localparam logic [31:0] A_BIT    = 32'h10;
    localparam logic [31:0] A_SOF    = 32'h14;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] awaddr, wdata, araddr, rdata, tdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic tvalid, tready, sof, locked;

    rx_prbs_checker #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_LOCK_CNT(LOCK_N),
        .C_LOSS_CNT(LOSS_N)
    ) dut (
        .s_axi_aclk(clk),
        .s_axi_aresetn(rstn),
        .s_axi_awaddr(awaddr),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bresp(bresp),
        .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_araddr(araddr),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata(rdata),
        .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid),
        .s_axi_rready(rready),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .s_axis_sof(sof),
        .s_axis_tdata(tdata),
        .o_locked(locked)
    );

    // ---------------- bookkeeping ----------------
    int n_asserts = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 search, 2 locked
    int          m_mode;
    bit          m_en;
    bit          m_seen_first;
    int          m_run_ok;
    int          m_run_bad;
    logic [31:0] m_exp;
    longint      m_word, m_err, m_bits, m_sof;

    function automatic logic [31:0] prbs(input logic [31:0] w);
        logic [31:0] fb;
        fb = ((w >> 31) ^ (w >> 21) ^ (w >> 1) ^ w) & 32'd1;
        return (w << 1) | fb;
    endfunction

    function automatic longint sat(input longint v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_en = 0; m_seen_first = 0;
        m_run_ok = 0; m_run_bad = 0; m_exp = 0;
        m_word = 0; m_err = 0; m_bits = 0; m_sof = 0;
    endtask

    task automatic model_beat(input logic [31:0] d, input bit s);
        logic [31:0] diff;
        if (!m_en) return;
        if (s) m_sof = sat(m_sof + 1);
        if (m_mode == 1) begin
            if (!m_seen_first) begin
                m_seen_first = 1;
            end else if (d == m_exp) begin
                m_run_ok++;
                if (m_run_ok >= LOCK_N) begin
                    m_mode = 2;
                    m_run_bad = 0;
                end
            end else begin
                m_run_ok = 0;
            end
            m_exp = prbs(d);
        end else if (m_mode == 2) begin
            diff = d ^ m_exp;
            m_word = sat(m_word + 1);
            m_bits = sat(m_bits + $countones(diff));
            if (diff != 0) begin
                m_err = sat(m_err + 1);
                m_run_bad++;
                if (m_run_bad >= LOSS_N) begin
                    m_mode = 1; m_run_ok = 0; m_run_bad = 0;
                    m_exp = prbs(d);
                end else begin
                    m_exp = prbs(m_exp);
                end
            end else begin
                m_run_bad = 0;
                m_exp = prbs(m_exp);
            end
        end
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
        if (addr[4:2] != 3'd0) return;
        if (data[1]) begin
            m_word = 0; m_err = 0; m_bits = 0; m_sof = 0;
        end
        if (data[0] && !m_en) begin
            m_mode = 1; m_seen_first = 0; m_run_ok = 0;
        end else if (!data[0]) begin
            m_mode = 0; m_run_ok = 0; m_run_bad = 0;
        end
        m_en = data[0];
    endtask

    // ---------------- driver tasks ----------------
    logic tready_after;
    logic locked_after;

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input bit with_beat, input logic [31:0] bdata, input bit bsof);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        n = 0;
        while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
        check("aw_w_ready_seen", {31'd0, awready && wready}, 32'd1);
        if (with_beat) begin tvalid = 1; tdata = bdata; sof = bsof; end
        @(posedge clk);
        if (with_beat) model_beat(bdata, bsof);
        model_write(addr, data);
        @(negedge clk);
        awvalid = 0; wvalid = 0; tvalid = 0; sof = 0;
        tready_after = tready;
        locked_after = locked;
        bready = 1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("bvalid_seen", {31'd0, bvalid}, 32'd1);
        check("bresp", {30'd0, bresp}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("arready_seen", {31'd0, arready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 0; rready = 1;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        check("rvalid_seen", {31'd0, rvalid}, 32'd1);
        data = rdata; resp = rresp;
        @(posedge clk);
        @(negedge clk);
        rready = 0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check(tag, d, exp);
    endtask

    task automatic send_beat(input logic [31:0] d, input bit s);
        @(negedge clk);
        tvalid = 1; tdata = d; sof = s;
        @(posedge clk);
        model_beat(d, s);
        #1;
        tvalid = 0; sof = 0;
    endtask

    task automatic check_model_all(input string tag);
        read_check({tag, "_word"},   A_WORD,   32'(m_word));
        read_check({tag, "_err"},    A_ERR,    32'(m_err));
        read_check({tag, "_bits"},   A_BIT,    32'(m_bits));
        read_check({tag, "_sof"},    A_SOF,    32'(m_sof));
        read_check({tag, "_status"}, A_STATUS, 32'(m_mode));
        check({tag, "_locked"}, {31'd0, locked}, {31'd0, m_mode == 2});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [31:0] g, mask, d;
    logic [1:0]  rr;

    initial begin
        awaddr = 0; wdata = 0; wstrb = 0; awvalid = 0; wvalid = 0; bready = 0;
        araddr = 0; arvalid = 0; rready = 0;
        tvalid = 0; tdata = 0; sof = 0;
        model_reset();

        // reset values while held in reset
        repeat (3) @(negedge clk);
        check("rst_locked",  {31'd0, locked},  32'd0);
        check("rst_tready",  {31'd0, tready},  32'd0);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata,            32'd0);
        check("rst_resps",   {28'd0, bresp, rresp}, 32'd0);
        rstn = 1;
        read_check("rst_status", A_STATUS, 32'd0);
        read_check("rst_ctrl",   A_CTRL,   32'd0);
        read_check("rst_word",   A_WORD,   32'd0);

        // enable and lock onto 1, 3, 6, ...
        axi_write(A_CTRL, 32'd1, 0, 0, 0);
        check("en_tready", {31'd0, tready_after}, 32'd1);
        read_check("en_status", A_STATUS, 32'd1);
        g = 32'd1;
        for (int i = 1; i <= 10; i++) begin
            send_beat(g, 0);
            g = prbs(g);
            if (i == 4) check("lock_not_yet", {31'd0, locked}, 32'd0);
            if (i == 5) check("lock_after_5", {31'd0, locked}, 32'd1);
        end
        read_check("lock_word", A_WORD,   32'd5);
        read_check("lock_err",  A_ERR,    32'd0);
        read_check("lock_bits", A_BIT,    32'd0);
        read_check("lock_stat", A_STATUS, 32'd2);

        // one corrupted beat while locked
        send_beat(g ^ 32'h0000_000F, 0);
        g = prbs(g);
        for (int i = 0; i < 3; i++) begin send_beat(g, 0); g = prbs(g); end
        read_check("corrupt1_err",  A_ERR, 32'd1);
        read_check("corrupt1_bits", A_BIT, 32'd4);
        check("corrupt1_locked", {31'd0, locked}, 32'd1);

        // random corruptions and frame starts
        for (int i = 0; i < 40; i++) begin
            mask = ($urandom_range(0, 4) == 0) ? $urandom() : 32'd0;
            send_beat(g ^ mask, $urandom_range(0, 3) == 0);
            g = prbs(g);
        end
        check_model_all("rand1");

        // relock if needed, clear, then four corrupted beats drop lock
        for (int i = 0; i < 12; i++) begin send_beat(g, 0); g = prbs(g); end
        check("relock", {31'd0, locked}, 32'd1);
        axi_write(A_CTRL, 32'd3, 0, 0, 0);
        read_check("clr_err", A_ERR, 32'd0);
        for (int i = 0; i < 4; i++) begin
            mask = $urandom();
            if (mask == 32'd0) mask = 32'd1;
            send_beat(g ^ mask, 0);
            g = prbs(g);
        end
        read_check("loss_status", A_STATUS, 32'd1);
        check("loss_locked", {31'd0, locked}, 32'd0);
        read_check("loss_err", A_ERR, 32'd4);

        // random stream from the search state
        for (int i = 0; i < 40; i++) begin
            mask = ($urandom_range(0, 5) == 0) ? ($urandom() | 32'd1) : 32'd0;
            send_beat(g ^ mask, $urandom_range(0, 2) == 0);
            g = prbs(g);
        end
        check_model_all("rand2");

        // clear on the same edge as an accepted sof beat
        axi_write(A_CTRL, 32'd3, 1, g, 1);
        g = prbs(g);
        read_check("clrbeat_word", A_WORD, 32'd0);
        read_check("clrbeat_err",  A_ERR,  32'd0);
        read_check("clrbeat_bits", A_BIT,  32'd0);
        read_check("clrbeat_sof",  A_SOF,  32'd0);

        // three frame starts, then disable
        for (int i = 0; i < 3; i++) begin send_beat(g, 1); g = prbs(g); end
        read_check("sof_cnt3", A_SOF, 32'd3);
        axi_write(A_CTRL, 32'd0, 0, 0, 0);
        check("dis_tready", {31'd0, tready_after}, 32'd0);
        check("dis_locked", {31'd0, locked_after}, 32'd0);
        read_check("dis_status", A_STATUS, 32'd0);

        // unmapped accesses
        axi_read(32'h1C, d, rr);
        check("unmapped_rdata", d, 32'd0);
        check("unmapped_rresp", {30'd0, rr}, 32'd0);
        read_check("unmapped_18", 32'h18, 32'd0);
        axi_write(32'h18, 32'd1, 0, 0, 0);
        check("unmapped_wr_tready", {31'd0, tready_after}, 32'd0);
        read_check("unmapped_wr_ctrl", A_CTRL, 32'd0);

        // reset in the middle of a locked stream
        axi_write(A_CTRL, 32'd1, 0, 0, 0);
        g = $urandom();
        if (g == 32'd0) g = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin send_beat(g, i == 0); g = prbs(g); end
        check_model_all("pre_rst");
        @(negedge clk);
        tvalid = 1; tdata = g;
        #2 rstn = 0;
        #1;
        model_reset();
        check("mid_rst_locked", {31'd0, locked}, 32'd0);
        check("mid_rst_tready", {31'd0, tready}, 32'd0);
        repeat (2) @(negedge clk);
        tvalid = 0;
        rstn = 1;
        repeat (3) @(negedge clk);
        check("post_rst_tready", {31'd0, tready}, 32'd0);
        read_check("post_rst_status", A_STATUS, 32'd0);
        read_check("post_rst_word",   A_WORD,   32'd0);
        read_check("post_rst_sof",    A_SOF,    32'd0);
        axi_write(A_CTRL, 32'd1, 0, 0, 0);
        check("re_en_tready", {31'd0, tready_after}, 32'd1);
        read_check("re_en_status", A_STATUS, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
